sseg_scan_ctrl: RTL and testbench

Digit-scan controller that sits directly upstream of the four-digit seven-segment driver (sseg4). It generates the 2-bit digit select at a fixed refresh rate and presents the 4-bit nibble for the selected digit from a 16-bit display value. It also flags leading-zero blanking. Value updates are double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/sseg_scan_ctrl.sv | 92 +++++++++
 tb/tb_sseg_scan_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
// Digit-scan controller for a four-digit seven-segment driver: refresh prescaler,
// digit select, leading-zero blanking and frame-synchronous double-buffered value updates.
module sseg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          BLANK_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    output logic [1:0]  digit_sel,
    output logic [3:0]  nibble,
    output logic        blank,
    output logic        frame_tick,
    output logic        pending
);

    localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [1:0] LAST_DIGIT = 2'd3;

    logic [PRESC_W-1:0] presc;
    logic [15:0]        shadow;
    logic [15:0]        pend_reg;
    logic               terminal_c;
    logic               boundary_c;

    // A frame ends on the terminal prescaler cycle of the last digit.
    assign terminal_c = (presc == PRESC_LAST);
    assign boundary_c = terminal_c && (digit_sel == LAST_DIGIT);

    // Refresh prescaler and digit scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            digit_sel  <= 2'd0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary_c;
            if (terminal_c) begin
                presc     <= '0;
                digit_sel <= digit_sel + 2'd1;
            end else begin
                presc     <= presc + PRESC_W'(1);
            end
        end
    end

    // Double buffer: a load at the boundary bypasses the pending slot entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= 16'h0000;
            pend_reg <= 16'h0000;
            pending  <= 1'b0;
        end else if (boundary_c) begin
            if (load) begin
                shadow <= value;
            end else if (pending) begin
                shadow <= pend_reg;
            end
            pending <= 1'b0;
        end else if (load) begin
            pend_reg <= value;
            pending  <= 1'b1;
        end
    end

    // Digit data and leading-zero detection, straight from the registered state.
    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        case (digit_sel)
            2'd0: begin
                nibble = shadow[3:0];
                blank  = 1'b0;
            end
            2'd1: begin
                nibble = shadow[7:4];
                blank  = BLANK_EN && (shadow[15:4] == 12'h000);
            end
            2'd2: begin
                nibble = shadow[11:8];
                blank  = BLANK_EN && (shadow[15:8] == 8'h00);
            end
            default: begin
                nibble = shadow[15:12];
                blank  = BLANK_EN && (shadow[15:12] == 4'h0);
            end
        endcase
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench: two scan controllers (divide-by-4 with blanking, divide-by-1 without)
// compared every cycle against a cycle-count based reference model.
module tb_sseg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        load;

    logic [1:0] ds0, ds1;
    logic [3:0] nb0, nb1;
    logic       bl0, bl1, ft0, ft1, pd0, pd1;

    int checks = 0;
    int errors = 0;

    // Reference model state per instance
    int unsigned m_cyc    [2];
    logic [15:0] m_shadow [2];
    logic [15:0] m_pval   [2];
    logic        m_pend   [2];
    logic        m_tick   [2];

    sseg_scan_ctrl #(.REFRESH_DIV(4), .BLANK_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .digit_sel(ds0), .nibble(nb0), .blank(bl0), .frame_tick(ft0), .pending(pd0)
    );

    sseg_scan_ctrl #(.REFRESH_DIV(1), .BLANK_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .digit_sel(ds1), .nibble(nb1), .blank(bl1), .frame_tick(ft1), .pending(pd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic bit be_of(input int i);
        return (i == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic check(input string tag, input int inst, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, inst, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic l, input logic [15:0] v);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_cyc[i]    = 0;
                m_shadow[i] = 16'h0000;
                m_pval[i]   = 16'h0000;
                m_pend[i]   = 1'b0;
                m_tick[i]   = 1'b0;
            end else begin
                bit bnd;
                bnd = ((m_cyc[i] % (4 * div_of(i))) == (4 * div_of(i) - 1));
                m_tick[i] = bnd;
                if (bnd) begin
                    if (l) m_shadow[i] = v;
                    else if (m_pend[i]) m_shadow[i] = m_pval[i];
                    m_pend[i] = 1'b0;
                end else if (l) begin
                    m_pval[i] = v;
                    m_pend[i] = 1'b1;
                end
                m_cyc[i]++;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int unsigned d;
            logic [15:0] sh;
            logic        eb;
            d  = (m_cyc[i] / div_of(i)) % 4;
            sh = m_shadow[i] >> (4 * d);
            eb = be_of(i) && (d != 0) && (sh == 16'h0000);
            check("digit_sel",  i, (i == 0) ? 16'(ds0) : 16'(ds1), 16'(d));
            check("nibble",     i, (i == 0) ? 16'(nb0) : 16'(nb1), 16'(sh[3:0]));
            check("blank",      i, (i == 0) ? 16'(bl0) : 16'(bl1), 16'(eb));
            check("frame_tick", i, (i == 0) ? 16'(ft0) : 16'(ft1), 16'(m_tick[i]));
            check("pending",    i, (i == 0) ? 16'(pd0) : 16'(pd1), 16'(m_pend[i]));
        end
    endtask

    task automatic step(input logic r, input logic l, input logic [15:0] v);
        @(negedge clk);
        rst   = r;
        load  = l;
        value = v;
        @(posedge clk);
        model_update(r, l, v);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0000);
    endtask

    // Idle until instance 0 is at the given cycle position within its 16-cycle frame.
    task automatic run_until_phase(input int unsigned ph);
        int guard;
        guard = 0;
        while (((m_cyc[0] % 16) != ph) && (guard < 64)) begin
            step(1'b0, 1'b0, 16'h0000);
            guard++;
        end
        checks++;
        if ((m_cyc[0] % 16) != ph) begin
            errors++;
            $error("FAIL phase_wait observed=%0d expected=%0d", m_cyc[0] % 16, ph);
        end
    endtask

    initial begin
        logic [15:0] rv;
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 0; m_shadow[i] = '0; m_pval[i] = '0; m_pend[i] = 1'b0; m_tick[i] = 1'b0;
        end
        rst = 1'b1; load = 1'b0; value = 16'h0000;

        step(1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        idle(36);

        // Mid-frame load while digit 1 is scanned
        run_until_phase(5);
        step(1'b0, 1'b1, 16'h12A4);
        idle(32);

        // Two loads in one frame: last one wins
        run_until_phase(2);
        step(1'b0, 1'b1, 16'h0005);
        run_until_phase(10);
        step(1'b0, 1'b1, 16'h0300);
        idle(24);

        // Load exactly on the boundary cycle while another value is pending
        run_until_phase(3);
        step(1'b0, 1'b1, 16'h1111);
        run_until_phase(15);
        step(1'b0, 1'b1, 16'hBEEF);
        idle(20);

        // Reset while a value is pending at digit 2
        run_until_phase(9);
        step(1'b0, 1'b1, 16'h5A5A);
        idle(1);
        step(1'b1, 1'b0, 16'h0000);
        idle(36);

        // Small value: blanking on instance 0, never on instance 1
        step(1'b0, 1'b1, 16'h0007);
        idle(36);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            rv = 16'($urandom);
            rv = rv >> (4 * $urandom_range(0, 4));
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0), rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
